// File: rtl/passthrough_arbiter.sv
`timescale 1ns/1ps
// passthrough_arbiter
// Round-robin arbiter that funnels NREQ valid/ready requesters into one
// registered output stage. The output register is the only storage; the
// grant decision is combinational from req_valid and the rotating pointer.
//
// Optional feature macro: PASSTHRU_ARB_LOCK_EN
//   When defined, a req_lock port lets the current winner keep exclusive
//   ownership of the channel across several words.
module passthrough_arbiter #(
    parameter int NREQ = 4,
    parameter int DW   = 8,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
`ifdef PASSTHRU_ARB_LOCK_EN
    input  logic [NREQ-1:0]    req_lock,
`endif
    output logic               out_valid,
    output logic [DW-1:0]      out_data,
    input  logic               out_ready,
    output logic [IDW-1:0]     grant_id
);

    // Channel occupancy: the output register is either empty or holds a word.
    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [0:0]     state_q,    state_d;
    logic [DW-1:0]  out_data_q, out_data_d;
    logic [IDW-1:0] grant_id_q, grant_id_d;
    logic [IDW-1:0] ptr_q,      ptr_d;
`ifdef PASSTHRU_ARB_LOCK_EN
    logic           lock_q,     lock_d;
    logic [IDW-1:0] owner_q,    owner_d;
`endif

    logic           ld;
    logic           found;
    logic [IDW-1:0] win;
    logic [IDW-1:0] win_inc;
    logic [DW-1:0]  req_word [NREQ];

    // Unpack the flat data bus so the winner's word is a simple array select.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign req_word[gi] = req_data[gi*DW +: DW];
        end
    endgenerate

    // The register can accept a new word when empty or when it drains this cycle.
    assign ld = (state_q == ST_EMPTY) || out_ready;

    // Pointer that follows the winner, wrapping back to requester 0.
    assign win_inc = (win == IDW'(NREQ-1)) ? '0 : (win + IDW'(1));

    // Winner search: first valid index scanning upward from ptr, modulo NREQ.
    always_comb begin
        int             idx;
        logic [IDW-1:0] idx_b;
        found = 1'b0;
        win   = '0;
        idx   = 0;
        idx_b = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            idx_b = IDW'(idx);
            if (!found && req_valid[idx_b]) begin
                found = 1'b1;
                win   = idx_b;
            end
        end
`ifdef PASSTHRU_ARB_LOCK_EN
        // A locked channel is reserved for its owner even when idle.
        if (lock_q) begin
            found = req_valid[owner_q];
            win   = owner_q;
        end
`endif
    end

    // One-hot ready toward the winner; held low while reset is asserted.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
            assign req_ready[gi] = !reset && ld && found && (win == IDW'(gi));
        end
    endgenerate

    // Next-state for the output register, pointer and lock ownership.
    always_comb begin
        state_d    = state_q;
        out_data_d = out_data_q;
        grant_id_d = grant_id_q;
        ptr_d      = ptr_q;
`ifdef PASSTHRU_ARB_LOCK_EN
        lock_d     = lock_q;
        owner_d    = owner_q;
`endif
        if (ld) begin
            if (found) begin
                state_d    = ST_FULL;
                out_data_d = req_word[win];
                grant_id_d = win;
                ptr_d      = win_inc;
`ifdef PASSTHRU_ARB_LOCK_EN
                if (req_lock[win]) begin
                    // Holding ownership: the pointer stays put until release.
                    lock_d  = 1'b1;
                    owner_d = win;
                    ptr_d   = ptr_q;
                end else begin
                    lock_d  = 1'b0;
                end
`endif
            end else begin
                // Drained with nobody waiting; data and id keep their last values.
                state_d = ST_EMPTY;
            end
        end
    end

    // State registers, cleared immediately by reset so a held word is dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_EMPTY;
            out_data_q <= '0;
            grant_id_q <= '0;
            ptr_q      <= '0;
`ifdef PASSTHRU_ARB_LOCK_EN
            lock_q     <= 1'b0;
            owner_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            out_data_q <= out_data_d;
            grant_id_q <= grant_id_d;
            ptr_q      <= ptr_d;
`ifdef PASSTHRU_ARB_LOCK_EN
            lock_q     <= lock_d;
            owner_q    <= owner_d;
`endif
        end
    end

    assign out_valid = (state_q == ST_FULL);
    assign out_data  = out_data_q;
    assign grant_id  = grant_id_q;

endmodule

// File: tb/tb_passthrough_arbiter.sv
`timescale 1ns/1ps
// Testbench for passthrough_arbiter: directed vectors, expected words are
// queued by the stimulus and consumed by an independent output monitor.
module tb_passthrough_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int IDW  = 2;

    logic               clk = 1'b0;
    logic               reset;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
`ifdef PASSTHRU_ARB_LOCK_EN
    logic [NREQ-1:0]    req_lock;
`endif
    logic               out_valid;
    logic [DW-1:0]      out_data;
    logic               out_ready;
    logic [IDW-1:0]     grant_id;

    int total = 0;
    int bad   = 0;

    // Expected {grant_id, data} in transfer order.
    logic [IDW+DW-1:0] sb [$];

    passthrough_arbiter #(.NREQ(NREQ), .DW(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
`ifdef PASSTHRU_ARB_LOCK_EN
        .req_lock  (req_lock),
`endif
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .grant_id  (grant_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic exp_push(input int id, input int d);
        sb.push_back({IDW'(id), DW'(d)});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: a word leaves the register at the next edge when valid && ready.
    always @(negedge clk) begin
        logic [IDW+DW-1:0] e;
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected: got id=%0d data=%02h want=none", grant_id, out_data);
            end else begin
                e = sb.pop_front();
                $display("xfer id=%0d data=%02h (expect id=%0d data=%02h)",
                         grant_id, out_data, e[DW +: IDW], e[DW-1:0]);
                chk("sb_data", 32'(out_data), 32'(e[DW-1:0]));
                chk("sb_id",   32'(grant_id), 32'(e[DW +: IDW]));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset     = 1'b1;
        req_valid = '1;
        out_ready = 1'b1;
`ifdef PASSTHRU_ARB_LOCK_EN
        req_lock  = '0;
`endif
        for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = 8'hA0 + 8'(i);

        // Reset held with every requester valid.
        repeat (3) begin
            @(negedge clk);
            chk("reset_out_valid", 32'(out_valid), 0);
            chk("reset_out_data",  32'(out_data),  0);
            chk("reset_grant_id",  32'(grant_id),  0);
            chk("reset_req_ready", 32'(req_ready), 0);
        end

        // Round-robin with all four continuously valid.
        exp_push(0, 'hA0); exp_push(1, 'hA1); exp_push(2, 'hA2);
        exp_push(3, 'hA3); exp_push(0, 'hA0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rr_first_ready", 32'(req_ready), 'b0001);
        repeat (5) @(posedge clk);
        #1;

        // Backpressure: requester 2 sends 5C, then 3 stalled cycles.
        req_valid = 4'b0100;
        req_data[2*DW +: DW] = 8'h5C;
        exp_push(2, 'h5C);
        step();
        out_ready = 1'b0;
        req_valid = 4'b0001;
        req_data[0*DW +: DW] = 8'h0A;
        repeat (3) begin
            @(negedge clk);
            chk("bp_out_valid", 32'(out_valid), 1);
            chk("bp_out_data",  32'(out_data),  'h5C);
            chk("bp_grant_id",  32'(grant_id),  2);
            chk("bp_req_ready", 32'(req_ready), 0);
            step();
        end
        out_ready = 1'b1;
        exp_push(0, 'h0A);
        @(negedge clk);
        chk("bp_resume_ready", 32'(req_ready), 'b0001);
        step();

        // Sparse requesters: 3 alone, then 1 alone.
        req_valid = 4'b1000;
        req_data[3*DW +: DW] = 8'h33;
        exp_push(3, 'h33);
        @(negedge clk);
        chk("sparse3_ready", 32'(req_ready), 'b1000);
        step();
        req_valid = 4'b0010;
        req_data[1*DW +: DW] = 8'h11;
        exp_push(1, 'h11);
        @(negedge clk);
        chk("sparse1_ready", 32'(req_ready), 'b0010);
        step();

        // Wrap order from ptr=2 with requesters 0,1,3 valid: 3, 0, 1.
        req_valid = 4'b1011;
        req_data[0*DW +: DW] = 8'h40;
        req_data[1*DW +: DW] = 8'h41;
        req_data[3*DW +: DW] = 8'h43;
        exp_push(3, 'h43); exp_push(0, 'h40); exp_push(1, 'h41);
        @(negedge clk);
        chk("wrap_first_ready", 32'(req_ready), 'b1000);
        repeat (3) @(posedge clk);
        #1;

        // Mid-transfer reset: hold 77 under backpressure, pulse reset between edges.
        req_valid = 4'b0100;
        req_data[2*DW +: DW] = 8'h77;
        step();
        out_ready = 1'b0;
        req_valid = 4'b1110;
        req_data[1*DW +: DW] = 8'h91;
        req_data[2*DW +: DW] = 8'h92;
        req_data[3*DW +: DW] = 8'h93;
        #2;
        chk("mr_pre_valid", 32'(out_valid), 1);
        chk("mr_pre_data",  32'(out_data),  'h77);
        reset = 1'b1;
        #1;
        chk("mr_out_valid", 32'(out_valid), 0);
        chk("mr_out_data",  32'(out_data),  0);
        chk("mr_grant_id",  32'(grant_id),  0);
        chk("mr_req_ready", 32'(req_ready), 0);
        #2;
        reset = 1'b0;
        out_ready = 1'b1;
        exp_push(1, 'h91);
        #1;
        chk("mr_first_ready", 32'(req_ready), 'b0010);
        step();
        req_valid = '0;

`ifdef PASSTHRU_ARB_LOCK_EN
        // Lock: move ptr to 1, then requester 1 locks for two words then releases.
        req_valid = 4'b0001;
        req_data[0*DW +: DW] = 8'h50;
        exp_push(0, 'h50);
        step();
        req_valid = 4'b0111;
        req_data[0*DW +: DW] = 8'hC0;
        req_data[1*DW +: DW] = 8'hB1;
        req_data[2*DW +: DW] = 8'hC2;
        req_lock  = 4'b0010;
        exp_push(1, 'hB1);
        @(negedge clk);
        chk("lk_ready1", 32'(req_ready), 'b0010);
        step();
        req_data[1*DW +: DW] = 8'hB2;
        exp_push(1, 'hB2);
        @(negedge clk);
        chk("lk_ready2", 32'(req_ready), 'b0010);
        step();
        req_data[1*DW +: DW] = 8'hB3;
        req_lock = '0;
        exp_push(1, 'hB3);
        step();
        exp_push(2, 'hC2);
        @(negedge clk);
        chk("lk_after_ready", 32'(req_ready), 'b0100);
        step();
        req_valid = '0;
`endif

        // Let the monitor consume everything still queued.
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        chk("sb_drained", 32'(sb.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
